// File: rtl/issue_ctrl_if.sv
// Decode/writeback/execute bundle seen by the issue controller.
// master = pipeline side driving decode and completion events, slave = issue_ctrl.
interface issue_ctrl_if;
    logic       dec_valid_i;
    logic [4:0] dec_rs1_i;
    logic [4:0] dec_rs2_i;
    logic       dec_use_rs1_i;
    logic       dec_use_rs2_i;
    logic [4:0] dec_rd_i;
    logic       dec_wr_rd_i;
    logic       wb_valid_i;
    logic [4:0] wb_rd_i;
    logic       kill_valid_i;
    logic [4:0] kill_rd_i;
    logic       branch_taken_i;
    logic       issue_o;
    logic       stall_o;
    logic       flush_o;
    logic [1:0] state_o;
    logic       err_o;

    modport master (
        output dec_valid_i, dec_rs1_i, dec_rs2_i, dec_use_rs1_i, dec_use_rs2_i,
        output dec_rd_i, dec_wr_rd_i, wb_valid_i, wb_rd_i,
        output kill_valid_i, kill_rd_i, branch_taken_i,
        input  issue_o, stall_o, flush_o, state_o, err_o
    );

    modport slave (
        input  dec_valid_i, dec_rs1_i, dec_rs2_i, dec_use_rs1_i, dec_use_rs2_i,
        input  dec_rd_i, dec_wr_rd_i, wb_valid_i, wb_rd_i,
        input  kill_valid_i, kill_rd_i, branch_taken_i,
        output issue_o, stall_o, flush_o, state_o, err_o
    );
endinterface

// File: rtl/issue_ctrl.sv
// Issue controller: per-register pending-writer scoreboard, RAW/WAW-saturation stall and branch flush sequencing.
// Optional macro ISSUE_CTRL_BYPASS_EN lets a source read issue in the same cycle as its producer's writeback.
module issue_ctrl #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    issue_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [2:0] flush_cnt;
    logic [2:0] flush_cnt_next;
    logic       flush_q;
    logic       err;

    logic [1:0] count      [32];
    logic [1:0] count_next [32];
    logic [2:0] count_up   [32];
    logic [2:0] count_dn   [32];
    logic [2:0] count_diff [32];
    logic [31:0] underflow;

    logic [31:0] wr_hit;
    logic [31:0] wb_hit;
    logic [31:0] kill_hit;

    logic rs1_bypass;
    logic rs2_bypass;
    logic rs1_hazard;
    logic rs2_hazard;
    logic rd_hazard;
    logic hazard;
    logic issue;
    logic stall;

`ifdef ISSUE_CTRL_BYPASS_EN
    // A single outstanding writer retiring this very cycle can be forwarded from writeback.
    assign rs1_bypass = (count[bus.dec_rs1_i] == 2'd1) & bus.wb_valid_i & (bus.wb_rd_i == bus.dec_rs1_i);
    assign rs2_bypass = (count[bus.dec_rs2_i] == 2'd1) & bus.wb_valid_i & (bus.wb_rd_i == bus.dec_rs2_i);
`else
    assign rs1_bypass = 1'b0;
    assign rs2_bypass = 1'b0;
`endif

    assign rs1_hazard = bus.dec_use_rs1_i & (bus.dec_rs1_i != 5'd0)
                      & (count[bus.dec_rs1_i] != 2'd0) & ~rs1_bypass;
    assign rs2_hazard = bus.dec_use_rs2_i & (bus.dec_rs2_i != 5'd0)
                      & (count[bus.dec_rs2_i] != 2'd0) & ~rs2_bypass;
    // A saturated counter cannot record another writer, so the destination must wait.
    assign rd_hazard  = bus.dec_wr_rd_i & (bus.dec_rd_i != 5'd0)
                      & (count[bus.dec_rd_i] == 2'd3);
    assign hazard     = bus.dec_valid_i & (rs1_hazard | rs2_hazard | rd_hazard);

    always_comb begin
        wr_hit   = '0;
        wb_hit   = '0;
        kill_hit = '0;
        if (issue && bus.dec_wr_rd_i && bus.dec_rd_i != 5'd0) begin
            wr_hit[bus.dec_rd_i] = 1'b1;
        end
        if (bus.wb_valid_i && bus.wb_rd_i != 5'd0) begin
            wb_hit[bus.wb_rd_i] = 1'b1;
        end
        if (bus.kill_valid_i && bus.kill_rd_i != 5'd0) begin
            kill_hit[bus.kill_rd_i] = 1'b1;
        end
    end

    // Increment and both decrements land together; going below zero clamps and flags underflow.
    always_comb begin
        underflow = '0;
        for (int i = 0; i < 32; i++) begin
            count_up[i]   = {1'b0, count[i]} + {2'b00, wr_hit[i]};
            count_dn[i]   = {2'b00, wb_hit[i]} + {2'b00, kill_hit[i]};
            count_diff[i] = count_up[i] - count_dn[i];
            if (count_dn[i] > count_up[i]) begin
                count_next[i] = 2'd0;
                underflow[i]  = 1'b1;
            end else begin
                count_next[i] = count_diff[i][1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                count[i] <= 2'd0;
            end
            err <= 1'b0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                count[i] <= count_next[i];
            end
            err <= err | (|underflow);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            flush_cnt <= 3'd0;
            flush_q   <= 1'b0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
            flush_q   <= (state_next == FLUSH);
        end
    end

    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        if (bus.branch_taken_i) begin
            state_next     = FLUSH;
            flush_cnt_next = FLUSH_LOAD;
        end else begin
            case (state)
                RUN: begin
                    if (hazard) begin
                        state_next = STALL;
                    end
                end
                STALL: begin
                    if (!hazard) begin
                        state_next = RUN;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == 3'd0) begin
                        state_next = RUN;
                    end else begin
                        flush_cnt_next = flush_cnt - 3'd1;
                    end
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    always_comb begin
        issue = bus.dec_valid_i & ~hazard & (state != FLUSH) & ~bus.branch_taken_i;
        stall = bus.dec_valid_i & ~issue;
    end

    assign bus.issue_o = issue;
    assign bus.stall_o = stall;
    assign bus.flush_o = flush_q;
    assign bus.state_o = state;
    assign bus.err_o   = err;

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: directed scenarios plus randomized traffic against a counting reference model.
// Honours ISSUE_CTRL_BYPASS_EN the same way the design does.
module tb_issue_ctrl;

    localparam int FC = 2;
`ifdef ISSUE_CTRL_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    issue_ctrl_if bus ();

    issue_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: pending writer counts, remaining flush cycles, stall flag, sticky error.
    int m_cnt [32];
    int m_flush_left;
    bit m_stalled;
    bit m_err;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic bit srcHaz(bit use_src, int r);
        if (!use_src || r == 0 || m_cnt[r] == 0) return 1'b0;
        if (BYPASS && m_cnt[r] == 1 && bus.wb_valid_i && int'(bus.wb_rd_i) == r) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit modelHazard();
        bit rd_full;
        rd_full = bus.dec_wr_rd_i && bus.dec_rd_i != 5'd0 && m_cnt[int'(bus.dec_rd_i)] == 3;
        return bus.dec_valid_i && (srcHaz(bus.dec_use_rs1_i, int'(bus.dec_rs1_i)) ||
                                   srcHaz(bus.dec_use_rs2_i, int'(bus.dec_rs2_i)) || rd_full);
    endfunction

    function automatic bit modelIssue();
        return bus.dec_valid_i && !modelHazard() && m_flush_left == 0 && !bus.branch_taken_i;
    endfunction

    function automatic int modelState();
        if (m_flush_left > 0) return 2;
        return m_stalled ? 1 : 0;
    endfunction

    task automatic resetModel();
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_flush_left = 0;
        m_stalled    = 1'b0;
        m_err        = 1'b0;
    endtask

    task automatic applyStimulus(input bit dv, input int rs1, input bit u1, input int rs2, input bit u2,
                                 input int rd, input bit wr, input bit wbv, input int wbrd,
                                 input bit kv, input int krd, input bit br);
        bit exp_issue;
        bus.dec_valid_i    = dv;
        bus.dec_rs1_i      = 5'(rs1);
        bus.dec_use_rs1_i  = u1;
        bus.dec_rs2_i      = 5'(rs2);
        bus.dec_use_rs2_i  = u2;
        bus.dec_rd_i       = 5'(rd);
        bus.dec_wr_rd_i    = wr;
        bus.wb_valid_i     = wbv;
        bus.wb_rd_i        = 5'(wbrd);
        bus.kill_valid_i   = kv;
        bus.kill_rd_i      = 5'(krd);
        bus.branch_taken_i = br;
        #1;
        exp_issue = modelIssue();
        checkOutput("issue", 32'(bus.issue_o), 32'(exp_issue));
        checkOutput("stall", 32'(bus.stall_o), 32'(dv && !exp_issue));
        checkOutput("flush", 32'(bus.flush_o), 32'(m_flush_left > 0));
        checkOutput("state", 32'(bus.state_o), 32'(modelState()));
        checkOutput("err",   32'(bus.err_o),   32'(m_err));
    endtask

    // Advance one clock edge and retire the current inputs into the model.
    task automatic step();
        int nxt [32];
        bit hz;
        bit iss;
        hz  = modelHazard();
        iss = modelIssue();
        for (int r = 0; r < 32; r++) nxt[r] = m_cnt[r];
        for (int r = 1; r < 32; r++) begin
            if (iss && bus.dec_wr_rd_i && int'(bus.dec_rd_i) == r) nxt[r]++;
            if (bus.wb_valid_i && int'(bus.wb_rd_i) == r) nxt[r]--;
            if (bus.kill_valid_i && int'(bus.kill_rd_i) == r) nxt[r]--;
            if (nxt[r] < 0) begin
                nxt[r] = 0;
                m_err  = 1'b1;
            end
        end
        @(posedge clk);
        for (int r = 0; r < 32; r++) m_cnt[r] = nxt[r];
        if (bus.branch_taken_i) begin
            m_flush_left = FC;
            m_stalled    = 1'b0;
        end else if (m_flush_left > 0) begin
            m_flush_left--;
            m_stalled = 1'b0;
        end else begin
            m_stalled = hz;
        end
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
    endtask

    initial begin
        int pend [$];
        bit dv, u1, u2, wr, wbv, kv, br;
        int rs1, rs2, rd, wbrd, krd;

        resetModel();
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #10;
        rst_n = 1'b1;
        step();

        // Back-to-back RAW on x5
        applyStimulus(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0);
        checkOutput("raw_writer_issue", 32'(bus.issue_o), 32'd1);
        step();
        applyStimulus(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("raw_reader_stall", 32'(bus.stall_o), 32'd1);
        step();
        applyStimulus(1, 5, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
        checkOutput("raw_state_stall", 32'(bus.state_o), 32'd1);
        checkOutput("raw_wb_cycle_issue", 32'(bus.issue_o), 32'(BYPASS));
        step();
        applyStimulus(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("raw_after_wb_issue", 32'(bus.issue_o), 32'd1);
        step();

        // x0 is never tracked
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        step();
        applyStimulus(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("x0_no_stall", 32'(bus.stall_o), 32'd0);
        step();

        // WAW saturation on x7
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0);
            checkOutput("waw_writer_issue", 32'(bus.issue_o), 32'd1);
            step();
        end
        applyStimulus(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0);
        checkOutput("waw_fourth_stall", 32'(bus.stall_o), 32'd1);
        step();
        applyStimulus(1, 0, 0, 0, 0, 7, 1, 1, 7, 0, 0, 0);
        checkOutput("waw_wb_cycle_stall", 32'(bus.stall_o), 32'd1);
        step();
        applyStimulus(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0);
        checkOutput("waw_fourth_issue", 32'(bus.issue_o), 32'd1);
        step();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0);
            step();
        end

        // Simultaneous issue/wb/kill on x9 from count 2
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0);
            step();
        end
        applyStimulus(1, 0, 0, 0, 0, 9, 1, 1, 9, 1, 9, 0);
        checkOutput("simul_issue", 32'(bus.issue_o), 32'd1);
        step();
        applyStimulus(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("simul_pending_stall", 32'(bus.stall_o), 32'd1);
        step();
        applyStimulus(1, 9, 1, 0, 0, 0, 0, 1, 9, 0, 0, 0);
        step();
        applyStimulus(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("simul_drained_issue", 32'(bus.issue_o), 32'd1);
        step();

        // Underflow on x3
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
        checkOutput("err_before_kill", 32'(bus.err_o), 32'd0);
        step();
        idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("err_sticky", 32'(bus.err_o), 32'd1);
        step();

        // Single branch pulse
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("br_pulse_issue", 32'(bus.issue_o), 32'd0);
        step();
        for (int k = 0; k < FC; k++) begin
            applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput("br_flush_high", 32'(bus.flush_o), 32'd1);
            checkOutput("br_flush_issue", 32'(bus.issue_o), 32'd0);
            checkOutput("br_flush_state", 32'(bus.state_o), 32'd2);
            step();
        end
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("br_flush_done", 32'(bus.flush_o), 32'd0);
        checkOutput("br_done_issue", 32'(bus.issue_o), 32'd1);
        step();

        // Second branch inside FLUSH extends the window
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("br2_first_flush", 32'(bus.flush_o), 32'd1);
        step();
        for (int k = 0; k < FC; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput("br2_extended_flush", 32'(bus.flush_o), 32'd1);
            step();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("br2_flush_done", 32'(bus.flush_o), 32'd0);
        step();

        // Asynchronous reset while stalled with pending counts
        applyStimulus(1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 0, 0);
        step();
        applyStimulus(1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        applyStimulus(1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_pre_state", 32'(bus.state_o), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_state", 32'(bus.state_o), 32'd0);
        checkOutput("rst_err", 32'(bus.err_o), 32'd0);
        checkOutput("rst_flush", 32'(bus.flush_o), 32'd0);
        checkOutput("rst_issue", 32'(bus.issue_o), 32'd1);
        checkOutput("rst_stall", 32'(bus.stall_o), 32'd0);
        resetModel();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Randomized traffic with legal completions
        for (int n = 0; n < 1500; n++) begin
            dv  = ($urandom_range(0, 3) != 0);
            rs1 = $urandom_range(0, 7);
            rs2 = $urandom_range(0, 7);
            rd  = $urandom_range(0, 7);
            u1  = $urandom_range(0, 1);
            u2  = $urandom_range(0, 1);
            wr  = ($urandom_range(0, 9) < 7);
            br  = ($urandom_range(0, 19) == 0);
            pend.delete();
            for (int r = 1; r < 32; r++) if (m_cnt[r] > 0) pend.push_back(r);
            wbv = 1'b0; wbrd = 0; kv = 1'b0; krd = 0;
            if (pend.size() > 0 && $urandom_range(0, 9) < 4) begin
                wbv  = 1'b1;
                wbrd = pend[$urandom_range(0, pend.size() - 1)];
            end
            if (pend.size() > 0 && $urandom_range(0, 9) == 0) begin
                kv  = 1'b1;
                krd = pend[$urandom_range(0, pend.size() - 1)];
                if (wbv && krd == wbrd && m_cnt[krd] < 2) kv = 1'b0;
            end
            applyStimulus(dv, rs1, u1, rs2, u2, rd, wr, wbv, wbrd, kv, krd, br);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/issue_ctrl.md
# issue_ctrl

Issue controller that sits between the decode stage and execute and decides each cycle whether the decoded instruction may issue. It tracks in-flight register writers in a per-register scoreboard and stalls decode on read-after-write hazards. It sequences pipeline flushes after a taken branch. It is the single source of the decode stall and flush controls for the pipeline.

## Interface
- FLUSH_CYCLES, default 2: cycles flush_o stays high after a taken branch (legal 1..7).
- clk  input  1  pipeline clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- dec_valid_i  input  1  decode holds a valid instruction.
- dec_rs1_i / dec_rs2_i  input  5 each  source register selects from decode.
- dec_use_rs1_i / dec_use_rs2_i  input  1 each  instruction actually reads rs1 / rs2.
- dec_rd_i  input  5  destination register.
- dec_wr_rd_i  input  1  instruction writes rd.
- wb_valid_i  input  1  writeback commits a register this cycle.
- wb_rd_i  input  5  register being committed.
- kill_valid_i  input  1  execute squashed an issued writer (wrong-path).
- kill_rd_i  input  5  rd of the squashed writer.
- branch_taken_i  input  1  execute resolved a taken branch this cycle.
- issue_o  output  1  decoded instruction issues this cycle (combinational).
- stall_o  output  1  hold fetch/decode (combinational).
- flush_o  output  1  squash fetch/decode contents (registered).
- state_o  output  2  FSM state: RUN=0, STALL=1, FLUSH=2.
- err_o  output  1  sticky scoreboard underflow flag.

## Operation
- Scoreboard: 2-bit pending count per register x1..x31. x0 is never tracked, and a read of x0 never hazards.
- Hazard: dec_valid_i and, for an enabled source with nonzero index, that register's count != 0. A destination whose count == 3 is also a hazard, because that count has saturated.
- issue_o = dec_valid_i & ~hazard & (state != FLUSH) & ~branch_taken_i.
- stall_o = dec_valid_i & ~issue_o.
- Count update per register each edge: +1 if issue_o & dec_wr_rd_i & rd match (rd != 0). −1 for each matching wb_valid_i and each matching kill_valid_i. The updates are applied together, so the net change lies in −2..+1.
- Underflow: a decrement of a count that is already 0 leaves the count at 0 and sets err_o. err_o clears only on reset.
- FSM transitions:
  - RUN: on a hazard, go to STALL.
  - STALL: when the hazard clears, return to RUN.
  - Any state: branch_taken_i → FLUSH, with the down-counter loaded to FLUSH_CYCLES−1.
  - FLUSH: decrement the counter each cycle. Leave to RUN when the counter is 0 and branch_taken_i is low.
  - branch_taken_i during FLUSH reloads the counter.
- branch_taken_i has priority over every other transition.

## Timing
- Reset: every count 0, state RUN, flush counter 0, flush_o 0, err_o 0.
- issue_o and stall_o are combinational from the inputs and the current scoreboard. There is no added latency.
- The scoreboard is visible one cycle after the issuing edge.
- flush_o is high for exactly FLUSH_CYCLES cycles, starting the cycle after branch_taken_i.
- Without bypass, a dependent instruction issues one cycle after the writeback of its producer.
- Reset asserted mid-operation clears all state immediately. Outputs take their reset values asynchronously.

## Configuration
- ISSUE_CTRL_BYPASS_EN defined:
  - A source hazard is suppressed when its register's count == 1 and wb_valid_i & wb_rd_i matches it in the same cycle. Execute takes that operand from the writeback bypass.
  - The dependent instruction issues in the same cycle as the producer's writeback.
- ISSUE_CTRL_BYPASS_EN not defined:
  - Hazards use the registered count only.

## Test plan
- Back-to-back RAW: issue write x5, then read x5 → stall_o=1. With wb x5 two cycles later, the read issues the cycle after wb (same cycle with ISSUE_CTRL_BYPASS_EN).
- x0: write x0, then read x0 → no stall, count stays 0.
- WAW saturation: issue three writers to x7 → count 3, and a fourth writer to x7 stalls. One wb x7 → the fourth issues next cycle.
- Simultaneous events: issue x9 with wb x9 and kill x9 on the same edge, starting from count 2 → count 1. A kill of x3 at count 0 → err_o=1 and stays high.
- Flush: branch_taken_i pulse with FLUSH_CYCLES=2 → flush_o high 2 cycles, issue_o=0 during the pulse and during FLUSH. A second branch in the FLUSH cycle extends flush to 2 cycles after it.
- Reset in STALL with pending counts → state RUN, all counts 0, outputs at reset values immediately.
